// File: rtl/packet_scheduler_if.sv
// Slot-offer and grant signals between the timing/producer side and the packet scheduler.
interface packet_scheduler_if;
    logic       packet_enable;
    logic       frame_start;
    logic       acr_request;
    logic [2:0] audio_samples_available;
    logic [7:0] packet_type;
    logic       acr_grant;
    logic       audio_grant;
    logic [2:0] audio_sample_count;
    logic [2:0] infoframe_grant;

    modport master (
        output packet_enable, frame_start, acr_request, audio_samples_available,
        input  packet_type, acr_grant, audio_grant, audio_sample_count, infoframe_grant
    );

    modport slave (
        input  packet_enable, frame_start, acr_request, audio_samples_available,
        output packet_type, acr_grant, audio_grant, audio_sample_count, infoframe_grant
    );
endinterface

// File: rtl/packet_scheduler.sv
// Data-island slot scheduler: picks one packet type per honoured slot offer and pulses the
// matching producer grant one cycle after the offer.
module packet_scheduler #(
    parameter int unsigned INFOFRAME_DIVIDER = 1,
    parameter int unsigned SLOT_CYCLES       = 32
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    packet_scheduler_if.slave bus
);
    localparam logic [7:0] PktNull    = 8'h00;
    localparam logic [7:0] PktAcr     = 8'h01;
    localparam logic [7:0] PktAudio   = 8'h02;
    localparam logic [7:0] PktAvi     = 8'h82;
    localparam logic [7:0] PktSpd     = 8'h83;
    localparam logic [7:0] PktAudioIf = 8'h84;

    localparam int unsigned      SlotW    = $clog2(SLOT_CYCLES + 1);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(SLOT_CYCLES - 1);
    localparam logic [7:0]       DivLast  = 8'(INFOFRAME_DIVIDER - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e           state_q, state_d;
    logic [SlotW-1:0] slot_cnt_q, slot_cnt_d;
    logic [7:0]       div_q, div_d;
    logic             acr_pending_q, acr_pending_d;
    logic [2:0]       if_pending_q, if_pending_d;
    logic [7:0]       packet_type_q, packet_type_d;
    logic             acr_grant_q, acr_grant_d;
    logic             audio_grant_q, audio_grant_d;
    logic [2:0]       audio_count_q, audio_count_d;
    logic [2:0]       if_grant_q, if_grant_d;
    logic             issue;
    logic             div_wrap;
    logic [2:0]       avail_min;

    assign avail_min = (bus.audio_samples_available >= 3'd4) ? 3'd4
                                                             : bus.audio_samples_available;

    // Slot FSM: an offer is only honoured from idle; the counter spans the whole slot.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        issue      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.packet_enable) begin
                    issue      = 1'b1;
                    state_d    = StIssue;
                    slot_cnt_d = SlotW'(1);
                end
            end
            StIssue: begin
                state_d    = StHold;
                slot_cnt_d = slot_cnt_q + 1'b1;
            end
            StHold: begin
                if (slot_cnt_q >= SlotLast) begin
                    state_d    = StIdle;
                    slot_cnt_d = '0;
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                slot_cnt_d = '0;
            end
        endcase
    end

    // Priority selection from registered pending state; grants are zero unless issuing.
    always_comb begin
        packet_type_d = packet_type_q;
        acr_grant_d   = 1'b0;
        audio_grant_d = 1'b0;
        audio_count_d = 3'd0;
        if_grant_d    = 3'b000;
        if (issue) begin
            if (bus.audio_samples_available >= 3'd4) begin
                packet_type_d = PktAudio;
                audio_grant_d = 1'b1;
                audio_count_d = avail_min;
            end else if (acr_pending_q) begin
                packet_type_d = PktAcr;
                acr_grant_d   = 1'b1;
            end else if (bus.audio_samples_available != 3'd0) begin
                packet_type_d = PktAudio;
                audio_grant_d = 1'b1;
                audio_count_d = avail_min;
            end else if (if_pending_q[0]) begin
                packet_type_d = PktAvi;
                if_grant_d    = 3'b001;
            end else if (if_pending_q[1]) begin
                packet_type_d = PktAudioIf;
                if_grant_d    = 3'b010;
            end else if (if_pending_q[2]) begin
                packet_type_d = PktSpd;
                if_grant_d    = 3'b100;
            end else begin
                packet_type_d = PktNull;
            end
        end
    end

    // Pending flags and frame divider; a same-cycle request beats the clear from issue.
    always_comb begin
        div_wrap      = bus.frame_start && (div_q >= DivLast);
        div_d         = div_q;
        if (bus.frame_start) begin
            div_d = div_wrap ? 8'd0 : div_q + 8'd1;
        end
        acr_pending_d = bus.acr_request | (acr_pending_q & ~acr_grant_d);
        if_pending_d  = (if_pending_q & ~if_grant_d) | {3{div_wrap}};
    end

    // State and output registers.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            slot_cnt_q    <= '0;
            div_q         <= 8'd0;
            acr_pending_q <= 1'b0;
            if_pending_q  <= 3'b000;
            packet_type_q <= PktNull;
            acr_grant_q   <= 1'b0;
            audio_grant_q <= 1'b0;
            audio_count_q <= 3'd0;
            if_grant_q    <= 3'b000;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            div_q         <= div_d;
            acr_pending_q <= acr_pending_d;
            if_pending_q  <= if_pending_d;
            packet_type_q <= packet_type_d;
            acr_grant_q   <= acr_grant_d;
            audio_grant_q <= audio_grant_d;
            audio_count_q <= audio_count_d;
            if_grant_q    <= if_grant_d;
        end
    end

    assign bus.packet_type        = packet_type_q;
    assign bus.acr_grant          = acr_grant_q;
    assign bus.audio_grant        = audio_grant_q;
    assign bus.audio_sample_count = audio_count_q;
    assign bus.infoframe_grant    = if_grant_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Bench for packet_scheduler: two instances (divider 1 and 3) share stimulus; a slot-level
// model predicts every output each cycle, and directed slots pin literal expectations.
module tb_packet_scheduler;
    localparam int SLOT = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pe = 1'b0;
    logic       fs = 1'b0;
    logic       acr = 1'b0;
    logic [2:0] avail = 3'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    packet_scheduler_if bus0();
    packet_scheduler_if bus1();

    assign bus0.packet_enable           = pe;
    assign bus0.frame_start             = fs;
    assign bus0.acr_request             = acr;
    assign bus0.audio_samples_available = avail;
    assign bus1.packet_enable           = pe;
    assign bus1.frame_start             = fs;
    assign bus1.acr_request             = acr;
    assign bus1.audio_samples_available = avail;

    packet_scheduler #(.INFOFRAME_DIVIDER(1), .SLOT_CYCLES(SLOT)) u_dut0 (
        .clk_pixel (clk),
        .reset_n   (reset_n),
        .bus       (bus0)
    );

    packet_scheduler #(.INFOFRAME_DIVIDER(3), .SLOT_CYCLES(SLOT)) u_dut1 (
        .clk_pixel (clk),
        .reset_n   (reset_n),
        .bus       (bus1)
    );

    logic [7:0] a_type [2];
    logic       a_acr  [2];
    logic       a_aud  [2];
    logic [2:0] a_cnt  [2];
    logic [2:0] a_if   [2];

    assign a_type[0] = bus0.packet_type;
    assign a_acr[0]  = bus0.acr_grant;
    assign a_aud[0]  = bus0.audio_grant;
    assign a_cnt[0]  = bus0.audio_sample_count;
    assign a_if[0]   = bus0.infoframe_grant;
    assign a_type[1] = bus1.packet_type;
    assign a_acr[1]  = bus1.acr_grant;
    assign a_aud[1]  = bus1.audio_grant;
    assign a_cnt[1]  = bus1.audio_sample_count;
    assign a_if[1]   = bus1.infoframe_grant;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slot-level model: an offer is honoured if at least SLOT cycles passed since the last one.
    int         cyc = 0;
    int         next_ok [2];
    bit         acr_p   [2];
    logic [2:0] ifp     [2];
    int         fcnt    [2];
    int         div_of  [2] = '{1, 3};
    logic [7:0] if_type [3] = '{8'h82, 8'h84, 8'h83};
    logic [7:0] e_type  [2];
    logic       e_acr   [2];
    logic       e_aud   [2];
    logic [2:0] e_cnt   [2];
    logic [2:0] e_if    [2];
    bit         found;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                next_ok[i] = 0;
                acr_p[i]   = 1'b0;
                ifp[i]     = 3'b000;
                fcnt[i]    = 0;
                e_type[i]  = 8'h00;
                e_acr[i]   = 1'b0;
                e_aud[i]   = 1'b0;
                e_cnt[i]   = 3'd0;
                e_if[i]    = 3'b000;
            end else begin
                e_acr[i] = 1'b0;
                e_aud[i] = 1'b0;
                e_cnt[i] = 3'd0;
                e_if[i]  = 3'b000;
                if (pe && cyc >= next_ok[i]) begin
                    next_ok[i] = cyc + SLOT;
                    e_type[i]  = 8'h00;
                    if (avail >= 3'd4) begin
                        e_type[i] = 8'h02;
                        e_aud[i]  = 1'b1;
                        e_cnt[i]  = 3'd4;
                    end else if (acr_p[i]) begin
                        e_type[i] = 8'h01;
                        e_acr[i]  = 1'b1;
                    end else if (avail >= 3'd1) begin
                        e_type[i] = 8'h02;
                        e_aud[i]  = 1'b1;
                        e_cnt[i]  = avail;
                    end else begin
                        found = 1'b0;
                        for (int b = 0; b < 3; b++) begin
                            if (!found && ifp[i][b]) begin
                                found     = 1'b1;
                                e_if[i]   = 3'(1 << b);
                                e_type[i] = if_type[b];
                            end
                        end
                    end
                end
                if (e_acr[i]) acr_p[i] = 1'b0;
                if (acr) acr_p[i] = 1'b1;
                ifp[i] = ifp[i] & ~e_if[i];
                if (fs) begin
                    fcnt[i]++;
                    if (fcnt[i] == div_of[i]) begin
                        fcnt[i] = 0;
                        ifp[i]  = 3'b111;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model; outputs must read zero while in reset.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                check(i == 0 ? "rst_type_d0" : "rst_type_d1", a_type[i], 8'h00);
                check(i == 0 ? "rst_grants_d0" : "rst_grants_d1",
                      {a_acr[i], a_aud[i], a_cnt[i], a_if[i]}, 8'h00);
            end else begin
                check(i == 0 ? "type_d0" : "type_d1", a_type[i], e_type[i]);
                check(i == 0 ? "acr_d0" : "acr_d1", 8'(a_acr[i]), 8'(e_acr[i]));
                check(i == 0 ? "aud_d0" : "aud_d1", 8'(a_aud[i]), 8'(e_aud[i]));
                check(i == 0 ? "cnt_d0" : "cnt_d1", 8'(a_cnt[i]), 8'(e_cnt[i]));
                check(i == 0 ? "ifg_d0" : "ifg_d1", 8'(a_if[i]), 8'(e_if[i]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        fs = 1'b1;
        tick(1);
        fs = 1'b0;
    endtask

    task automatic pulse_acr();
        acr = 1'b1;
        tick(1);
        acr = 1'b0;
    endtask

    // Offer one slot, pin literal results on both instances, then wait out `gap` cycles.
    // g0 packs DUT0 grants as {acr, audio, infoframe[2:0]}.
    task automatic issue_slot(input string name, input logic [7:0] t0, input logic [7:0] t1,
                              input logic [4:0] g0, input logic [2:0] c0, input int gap);
        pe = 1'b1;
        tick(1);
        pe = 1'b0;
        check({name, "_type0"}, bus0.packet_type, t0);
        check({name, "_type1"}, bus1.packet_type, t1);
        check({name, "_grant0"},
              8'({bus0.acr_grant, bus0.audio_grant, bus0.infoframe_grant}), 8'(g0));
        check({name, "_cnt0"}, 8'(bus0.audio_sample_count), 8'(c0));
        tick(gap);
    endtask

    initial begin
        reset_n = 1'b0;
        tick(3);
        check("reset_type", bus0.packet_type, 8'h00);
        check("reset_grants",
              8'({bus0.acr_grant, bus0.audio_grant, bus0.audio_sample_count,
                  bus0.infoframe_grant}), 8'h00);
        reset_n = 1'b1;
        tick(2);

        // InfoFrame round after one frame_start (divider 1 only)
        pulse_fs();
        issue_slot("if_avi", 8'h82, 8'h00, 5'b00001, 3'd0, SLOT - 1);
        issue_slot("if_aif", 8'h84, 8'h00, 5'b00010, 3'd0, SLOT - 1);
        issue_slot("if_spd", 8'h83, 8'h00, 5'b00100, 3'd0, SLOT - 1);
        issue_slot("null_a", 8'h00, 8'h00, 5'b00000, 3'd0, SLOT - 1);
        issue_slot("null_b", 8'h00, 8'h00, 5'b00000, 3'd0, SLOT - 1);

        // ACR ahead of low-fill audio, then audio
        avail = 3'd2;
        pulse_acr();
        issue_slot("acr_first", 8'h01, 8'h01, 5'b10000, 3'd0, SLOT - 1);
        issue_slot("aud_two", 8'h02, 8'h02, 5'b01000, 3'd2, SLOT - 1);

        // Overflow guard beats pending ACR; count saturates at 4
        avail = 3'd5;
        pulse_acr();
        issue_slot("aud_ovf", 8'h02, 8'h02, 5'b01000, 3'd4, SLOT - 1);
        avail = 3'd3;
        issue_slot("acr_after", 8'h01, 8'h01, 5'b10000, 3'd0, SLOT - 1);
        avail = 3'd0;

        // Offer 10 cycles into a slot is dropped; offer at +32 is honoured
        pulse_acr();
        issue_slot("gap_first", 8'h01, 8'h01, 5'b10000, 3'd0, 9);
        avail = 3'd1;
        pe = 1'b1;
        tick(1);
        pe = 1'b0;
        check("gap_ignored_type", bus0.packet_type, 8'h01);
        check("gap_ignored_grant",
              8'({bus0.acr_grant, bus0.audio_grant, bus0.infoframe_grant}), 8'h00);
        tick(SLOT - 11);
        issue_slot("gap_honour", 8'h02, 8'h02, 5'b01000, 3'd1, SLOT - 1);
        avail = 3'd0;

        // Divider 3: second frame_start still nothing on DUT1, third one wraps
        pulse_fs();
        issue_slot("div_two", 8'h82, 8'h00, 5'b00001, 3'd0, SLOT - 1);
        pulse_fs();
        issue_slot("div_three", 8'h82, 8'h82, 5'b00001, 3'd0, SLOT - 1);

        // Same-cycle request during ACR issue keeps ACR pending
        pulse_acr();
        pe = 1'b1;
        acr = 1'b1;
        tick(1);
        pe = 1'b0;
        acr = 1'b0;
        check("acr_same_type0", bus0.packet_type, 8'h01);
        check("acr_same_grant0", 8'(bus0.acr_grant), 8'h01);
        tick(SLOT - 1);
        issue_slot("acr_repeat", 8'h01, 8'h01, 5'b10000, 3'd0, SLOT - 1);

        // Reset in HOLD with AVI already sent (pending 110) drops everything
        avail = 3'd1;
        issue_slot("pre_rst", 8'h02, 8'h02, 5'b01000, 3'd1, 5);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_type0", bus0.packet_type, 8'h00);
        check("midrst_type1", bus1.packet_type, 8'h00);
        check("midrst_grants0",
              8'({bus0.acr_grant, bus0.audio_grant, bus0.audio_sample_count,
                  bus0.infoframe_grant}), 8'h00);
        tick(2);
        reset_n = 1'b1;
        avail = 3'd0;
        tick(1);
        issue_slot("post_null_a", 8'h00, 8'h00, 5'b00000, 3'd0, SLOT - 1);
        issue_slot("post_null_b", 8'h00, 8'h00, 5'b00000, 3'd0, SLOT - 1);
        pulse_fs();
        issue_slot("post_avi", 8'h82, 8'h00, 5'b00001, 3'd0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
